fs_en_sync_multi: RTL and testbench

Multi-channel sample-enable recovery block for the DVB-S2 datapath. Each channel takes a free-running sample-rate clock from a foreign domain and converts it into single-cycle enable pulses on `clk0`, with a programmable integer decimation. It also measures the period between edges in `clk0` cycles and reports per-channel lock. It supersedes the single-channel, fixed-ratio fs_en transfer logic and feeds the symbol and filter stages that run on `clk0`.

---
 rtl/fs_en_sync_multi.sv | 181 ++++++++++++++++++
 tb/tb_fs_en_sync_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_en_sync_multi.sv
// Multi-channel fs clock recovery: synchronizer, decimating enable and, when built with
// FS_EN_PERIOD_MON_EN, a per-channel edge period monitor with lock detection.
module fs_en_sync_multi #(
  parameter int CH          = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8,
  parameter int PER_W       = 16,
  parameter int LOCK_CNT    = 4
) (
  input  logic                clk0,
  input  logic                rst_n,
  input  logic [CH-1:0]       fs_clk_in,
  input  logic [CH*DIV_W-1:0] div_ratio,
  output logic [CH-1:0]       fs_en_out,
  output logic [CH*PER_W-1:0] edge_period,
  output logic [CH-1:0]       period_valid,
  output logic [CH-1:0]       lock
);

  if (SYNC_STAGES < 2 || LOCK_CNT < 1) begin : g_bad_cfg
    $error("fs_en_sync_multi: SYNC_STAGES must be >= 2 and LOCK_CNT >= 1");
  end

`ifdef FS_EN_PERIOD_MON_EN
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [PER_W-1:0] PCNT_MAX = {PER_W{1'b1}};
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [DIV_W-1:0]       r_dcnt;
    logic                   r_fs_en;
    logic                   w_edge;
    logic [DIV_W-1:0]       w_div;
    logic [DIV_W-1:0]       w_eff_m1;

    assign w_div    = div_ratio[g*DIV_W +: DIV_W];
    assign w_eff_m1 = (w_div == DIV_W'(0)) ? DIV_W'(0) : (w_div - DIV_W'(1));
    assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Synchronizer, edge history and divider; ratio is only looked at on an edge
    always_ff @(posedge clk0) begin
      if (!rst_n) begin
        r_sync  <= '0;
        r_hist  <= 1'b0;
        r_dcnt  <= DIV_W'(0);
        r_fs_en <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], fs_clk_in[g]};
        r_hist <= r_sync[SYNC_STAGES-1];
        if (w_edge) begin
          r_fs_en <= (r_dcnt == DIV_W'(0));
          r_dcnt  <= (r_dcnt >= w_eff_m1) ? DIV_W'(0) : (r_dcnt + DIV_W'(1));
        end else begin
          r_fs_en <= 1'b0;
        end
      end
    end

    assign fs_en_out[g] = r_fs_en;

`ifdef FS_EN_PERIOD_MON_EN
    typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PER_W-1:0]   r_pcnt;
    logic [PER_W-1:0]   r_prev;
    logic [PER_W-1:0]   r_period;
    logic [MATCH_W-1:0] r_match;
    logic               r_have_prev;
    logic               r_pv;
    logic               r_lock;
    logic [PER_W-1:0]   w_diff;
    logic               w_near;
    logic               w_sat;

    assign w_diff = (r_pcnt >= r_prev) ? (r_pcnt - r_prev) : (r_prev - r_pcnt);
    assign w_near = (w_diff <= PER_W'(1));
    assign w_sat  = (r_pcnt == PCNT_MAX);

    // Period capture and lock tracking; an edge coinciding with saturation restarts measurement
    always_ff @(posedge clk0) begin
      if (!rst_n) begin
        r_state     <= ST_IDLE;
        r_pcnt      <= PER_W'(0);
        r_prev      <= PER_W'(0);
        r_period    <= PER_W'(0);
        r_match     <= MATCH_W'(0);
        r_have_prev <= 1'b0;
        r_pv        <= 1'b0;
        r_lock      <= 1'b0;
      end else begin
        r_pv <= 1'b0;
        if (w_edge) begin
          r_pcnt <= PER_W'(1);
        end else if (!w_sat) begin
          r_pcnt <= r_pcnt + PER_W'(1);
        end else begin
          r_pcnt <= r_pcnt;
        end
        if (w_edge && (r_state != ST_IDLE)) begin
          r_period    <= r_pcnt;
          r_pv        <= 1'b1;
          r_prev      <= r_pcnt;
          r_have_prev <= 1'b1;
        end
        case (r_state)
          ST_IDLE: begin
            if (w_edge) begin
              r_state     <= ST_MEASURE;
              r_have_prev <= 1'b0;
              r_match     <= MATCH_W'(0);
              r_lock      <= 1'b0;
            end
          end
          ST_MEASURE: begin
            if (w_edge) begin
              if (!w_sat && r_have_prev && w_near) begin
                if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
                  r_state <= ST_LOCKED;
                  r_lock  <= 1'b1;
                end
                r_match <= r_match + MATCH_W'(1);
              end else begin
                r_match <= MATCH_W'(0);
              end
            end else if (w_sat) begin
              r_state <= ST_IDLE;
              r_match <= MATCH_W'(0);
              r_lock  <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (w_edge) begin
              if (w_sat || !w_near) begin
                r_state <= ST_MEASURE;
                r_match <= MATCH_W'(0);
                r_lock  <= 1'b0;
              end
            end else if (w_sat) begin
              r_state <= ST_IDLE;
              r_match <= MATCH_W'(0);
              r_lock  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_match <= MATCH_W'(0);
            r_lock  <= 1'b0;
          end
        endcase
      end
    end

    assign edge_period[g*PER_W +: PER_W] = r_period;
    assign period_valid[g]               = r_pv;
    assign lock[g]                       = r_lock;
`else
    logic r_lock;

    // Without the monitor, lock reads as asserted whenever out of reset
    always_ff @(posedge clk0) begin
      if (!rst_n) begin
        r_lock <= 1'b0;
      end else begin
        r_lock <= 1'b1;
      end
    end

    assign edge_period[g*PER_W +: PER_W] = PER_W'(0);
    assign period_valid[g]               = 1'b0;
    assign lock[g]                       = r_lock;
`endif
  end

endmodule

// File: tb/tb_fs_en_sync_multi.sv
// Scoreboard bench for fs_en_sync_multi: a driver emits fs clocks and queues expected
// pulse/edge cycles, a negedge monitor pops and compares every cycle.
module tb_fs_en_sync_multi;
  localparam int CH          = 2;
  localparam int SYNC_STAGES = 2;
  localparam int DIV_W       = 8;
  localparam int PER_W       = 8;
  localparam int LOCK_CNT    = 4;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int SAT         = (1 << PER_W) - 1;

  logic                clk0 = 1'b0;
  logic                rst_n;
  logic [CH-1:0]       fs_clk_in;
  logic [CH*DIV_W-1:0] div_ratio;
  logic [CH-1:0]       fs_en_out;
  logic [CH*PER_W-1:0] edge_period;
  logic [CH-1:0]       period_valid;
  logic [CH-1:0]       lock;

  fs_en_sync_multi #(
    .CH(CH), .SYNC_STAGES(SYNC_STAGES), .DIV_W(DIV_W), .PER_W(PER_W), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk0(clk0), .rst_n(rst_n), .fs_clk_in(fs_clk_in), .div_ratio(div_ratio),
    .fs_en_out(fs_en_out), .edge_period(edge_period), .period_valid(period_valid), .lock(lock)
  );

  always #5 clk0 = ~clk0;

  int cyc = 0;
  bit rst_q = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  // Scoreboard queues: cycle numbers at which a pulse / a detected edge is due
  int en_q[CH][$];
  int edge_q[CH][$];

  // Driver controls (written by the main sequence, consumed by the driver)
  int hi_len[CH];
  int lo_len[CH];
  int next_ratio[CH];
  bit hold[CH];
  bit glitch[CH];
  // Driver state and divider reference: position within the current decimation frame
  int cnt[CH];
  bit lvl[CH];
  int frame_pos[CH];

`ifdef FS_EN_PERIOD_MON_EN
  bit m_run[CH];
  bit m_have[CH];
  bit m_lock[CH];
  int m_last[CH];
  int m_prev[CH];
  int m_match[CH];
  int m_per[CH];
`endif

  always @(posedge clk0) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic cmp(input string nm, input int ch, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d @cyc %0d: got %0h, want %0h", nm, ch, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk0);
  endtask

  task automatic quiesce_reset();
    for (int ch = 0; ch < CH; ch++) hold[ch] = 1'b1;
    wait_cyc(20);
    rst_n = 1'b0;
    for (int ch = 0; ch < CH; ch++) frame_pos[ch] = 0;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(2);
    for (int ch = 0; ch < CH; ch++) hold[ch] = 1'b0;
  endtask

  // Driver: fs clocks change on the falling edge; every rise queues its expected outcome
  initial begin
    fs_clk_in = '0;
    div_ratio = {CH{8'd1}};
    forever begin
      @(negedge clk0);
      for (int ch = 0; ch < CH; ch++) begin
        int eff;
        if (cnt[ch] > 0) cnt[ch]--;
        if (cnt[ch] == 0) begin
          if (lvl[ch]) begin
            lvl[ch] = 1'b0;
            cnt[ch] = lo_len[ch];
          end else if (!hold[ch] && rst_n) begin
            lvl[ch] = 1'b1;
            cnt[ch] = hi_len[ch] + (glitch[ch] ? 2 : 0);
            glitch[ch] = 1'b0;
            div_ratio[ch*DIV_W +: DIV_W] = DIV_W'(next_ratio[ch]);
            eff = (next_ratio[ch] == 0) ? 1 : next_ratio[ch];
            if (frame_pos[ch] == 0) en_q[ch].push_back(cyc + LAT);
            frame_pos[ch] = (frame_pos[ch] + 1 >= eff) ? 0 : frame_pos[ch] + 1;
            edge_q[ch].push_back(cyc + LAT);
          end
        end
        fs_clk_in[ch] = lvl[ch];
      end
    end
  end

  // Monitor: every cycle, compare all outputs with the scoreboard / reference
  always @(negedge clk0) begin
    for (int ch = 0; ch < CH; ch++) begin
      bit due_en;
      bit due_edge;
      bit exp_pv;
      bit exp_lock;
      int exp_per;
      due_en   = (en_q[ch].size() > 0) && (en_q[ch][0] == cyc);
      due_edge = (edge_q[ch].size() > 0) && (edge_q[ch][0] == cyc);
      if (due_en) void'(en_q[ch].pop_front());
      if (due_edge) void'(edge_q[ch].pop_front());
      exp_pv   = 1'b0;
      exp_lock = 1'b0;
      exp_per  = 0;
      if (!rst_q) begin
        due_en = 1'b0;
`ifdef FS_EN_PERIOD_MON_EN
        m_run[ch] = 1'b0; m_have[ch] = 1'b0; m_lock[ch] = 1'b0;
        m_match[ch] = 0; m_per[ch] = 0; m_prev[ch] = 0; m_last[ch] = 0;
`endif
      end else begin
`ifdef FS_EN_PERIOD_MON_EN
        if (due_edge) begin
          if (m_run[ch]) begin
            int p;
            p = cyc - m_last[ch];
            exp_pv = 1'b1;
            m_per[ch] = p;
            if (p >= SAT) begin
              m_match[ch] = 0;
              m_lock[ch] = 1'b0;
            end else if (m_have[ch] && (p - m_prev[ch] <= 1) && (m_prev[ch] - p <= 1)) begin
              if (!m_lock[ch]) begin
                m_match[ch]++;
                if (m_match[ch] == LOCK_CNT) m_lock[ch] = 1'b1;
              end
            end else begin
              m_match[ch] = 0;
              m_lock[ch] = 1'b0;
            end
            m_prev[ch] = p;
            m_have[ch] = 1'b1;
          end else begin
            m_run[ch] = 1'b1; m_have[ch] = 1'b0; m_match[ch] = 0; m_lock[ch] = 1'b0;
          end
          m_last[ch] = cyc;
        end else if (m_run[ch] && (cyc - m_last[ch] >= SAT)) begin
          m_run[ch] = 1'b0; m_match[ch] = 0; m_lock[ch] = 1'b0;
        end
        exp_per  = m_per[ch];
        exp_lock = m_lock[ch];
`else
        exp_lock = 1'b1;
`endif
      end
      cmp("fs_en_out", ch, 32'(fs_en_out[ch]), int'(due_en));
      cmp("period_valid", ch, 32'(period_valid[ch]), int'(exp_pv));
      cmp("edge_period", ch, 32'(edge_period[ch*PER_W +: PER_W]), exp_per);
      cmp("lock", ch, 32'(lock[ch]), int'(exp_lock));
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int ch = 0; ch < CH; ch++) begin
      hi_len[ch] = 2; lo_len[ch] = 2; next_ratio[ch] = 1; hold[ch] = 1'b1;
    end
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(2);

    // 40 ns clock, divide by 1 on ch0; 60 ns clock, divide by 2 on ch1
    hi_len[1] = 3; lo_len[1] = 3; next_ratio[1] = 2;
    hold[0] = 1'b0; hold[1] = 1'b0;
    wait_cyc(60);

    // Divide by 3, then ratio 0 behaves as 1
    next_ratio[0] = 3;
    wait_cyc(80);
    next_ratio[0] = 0;
    wait_cyc(40);

    // Lock, a single 60 ns period, relock
    next_ratio[0] = 1;
    wait_cyc(40);
    glitch[0] = 1'b1;
    wait_cyc(60);

    // Stop ch1 long enough for the period counter to saturate
    hold[1] = 1'b1;
    wait_cyc(300);
    hold[1] = 1'b0;
    wait_cyc(80);

    // Edge gap exactly at saturation, then one cycle beyond it
    hi_len[1] = 3; lo_len[1] = 252;
    wait_cyc(560);
    lo_len[1] = 253;
    wait_cyc(560);
    lo_len[1] = 3;
    wait_cyc(60);

    // Reset while mid-divide
    next_ratio[0] = 3;
    wait_cyc(31);
    quiesce_reset();
    wait_cyc(60);

    // Randomised segments
    for (int s = 0; s < 24; s++) begin
      int c;
      for (int ch = 0; ch < CH; ch++) begin
        hi_len[ch] = $urandom_range(2, 7);
        lo_len[ch] = $urandom_range(2, 7);
        next_ratio[ch] = $urandom_range(0, 5);
      end
      if ($urandom_range(0, 3) == 0) glitch[$urandom_range(0, CH - 1)] = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        c = $urandom_range(0, CH - 1);
        hold[c] = 1'b1;
        wait_cyc($urandom_range(230, 300));
        hold[c] = 1'b0;
      end else begin
        wait_cyc($urandom_range(40, 160));
      end
      if ($urandom_range(0, 7) == 0) quiesce_reset();
    end

    for (int ch = 0; ch < CH; ch++) hold[ch] = 1'b1;
    wait_cyc(20);
    for (int ch = 0; ch < CH; ch++) begin
      cmp("pending_pulses", ch, 32'(en_q[ch].size()), 0);
      cmp("pending_edges", ch, 32'(edge_q[ch].size()), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
